// File: rtl/ef_gpio8_in_cond.sv
// ef_gpio8_in_cond: 8-bit GPIO input conditioner with a synchronizer, a prescaled per-bit glitch filter and edge pulses
module ef_gpio8_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FLT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       io_in,
  input  logic [7:0]       flt_en,
  input  logic [FLT_W-1:0] flt_len,
  input  logic [7:0]       prescale,
  output logic [7:0]       datai,
  output logic [7:0]       hi,
  output logic [7:0]       lo,
  output logic [7:0]       pe,
  output logic [7:0]       ne
);
  logic [7:0] sync_r [SYNC_STAGES];
  logic [7:0] sync, datai_d, cnt;
  logic [FLT_W-1:0] lm1;
  logic tick;
  assign sync = sync_r[SYNC_STAGES-1];
  assign tick = cnt >= prescale;
  assign lm1 = (flt_len == '0) ? '0 : flt_len - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '0;
      cnt <= '0;
      datai_d <= '0;
    end else begin
      sync_r[0] <= io_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
      cnt <= tick ? '0 : cnt + 1'b1;
      datai_d <= datai;
    end
  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic q;
    logic [FLT_W-1:0] c;
    // >= rather than == so a shortened flt_len lets an advanced count toggle at once
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q <= 1'b0;
        c <= '0;
      end else if (!flt_en[i]) begin
        q <= sync[i];
        c <= '0;
      end else if (tick) begin
        if (sync[i] == q) c <= '0;
        else if (c >= lm1) begin
          q <= ~q;
          c <= '0;
        end else c <= c + 1'b1;
      end
    assign datai[i] = q;
  end
  assign hi = datai;
  assign lo = ~datai;
  assign pe = datai & ~datai_d;
  assign ne = ~datai & datai_d;
endmodule

// File: tb/tb_ef_gpio8_in_cond.sv
// tb_ef_gpio8_in_cond: directed scoreboard bench for the GPIO input conditioner
module tb_ef_gpio8_in_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] io_in = '0, flt_en = '0, prescale = '0;
  logic [3:0] flt_len = 4'd1;
  logic [7:0] datai, hi, lo, pe, ne;
  int checks = 0, errors = 0;
  typedef struct packed {logic [7:0] d, p, n;} exp_t;
  exp_t sb[$];

  ef_gpio8_in_cond #(.SYNC_STAGES(2), .FLT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .flt_en(flt_en), .flt_len(flt_len),
    .prescale(prescale), .datai(datai), .hi(hi), .lo(lo), .pe(pe), .ne(ne)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".datai"}, datai, e.d);
    chk({tag, ".hi"}, hi, e.d);
    chk({tag, ".lo"}, lo, ~e.d);
    chk({tag, ".pe"}, pe, e.p);
    chk({tag, ".ne"}, ne, e.n);
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic [7:0] p, input logic [7:0] n);
    exp_t e;
    sb.push_back('{d: d, p: p, n: n});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  task automatic hold(input string tag, input int cnt, input logic [7:0] d);
    for (int k = 0; k < cnt; k++) step(tag, d, 8'h00, 8'h00);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_all("reset", '{d: 8'h00, p: 8'h00, n: 8'h00});
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold("idle", 3, 8'h00);
    io_in = 8'hA5;
    hold("unflt_rise_wait", 2, 8'h00);
    step("unflt_rise", 8'hA5, 8'hA5, 8'h00);
    hold("unflt_rise_hold", 2, 8'hA5);
    io_in = 8'h00;
    hold("unflt_fall_wait", 2, 8'hA5);
    step("unflt_fall", 8'h00, 8'h00, 8'hA5);
    hold("unflt_fall_hold", 2, 8'h00);
    flt_en = 8'hFF;
    flt_len = 4'd4;
    io_in = 8'h01;
    hold("glitch_on", 3, 8'h00);
    io_in = 8'h00;
    hold("glitch_off", 8, 8'h00);
    io_in = 8'h01;
    hold("accept_wait", 5, 8'h00);
    step("accept", 8'h01, 8'h01, 8'h00);
    hold("accept_hold", 2, 8'h01);
    io_in = 8'h00;
    hold("accept_fall_wait", 5, 8'h01);
    step("accept_fall", 8'h00, 8'h00, 8'h01);
    hold("accept_fall_hold", 2, 8'h00);
    prescale = 8'd9;
    flt_len = 4'd2;
    io_in = 8'hFF;
    hold("presc_wait", 19, 8'h00);
    step("presc", 8'hFF, 8'hFF, 8'h00);
    step("presc_hold", 8'hFF, 8'h00, 8'h00);
    prescale = 8'd0;
    flt_len = 4'd4;
    io_in = 8'h00;
    hold("midcount", 4, 8'hFF);
    io_in = 8'hFF;
    rst_n = 1'b0;
    #1 chk_all("rst_mid", '{d: 8'h00, p: 8'h00, n: 8'h00});
    step("rst_hold", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    hold("rst_rel_wait", 5, 8'h00);
    step("rst_rel", 8'hFF, 8'hFF, 8'h00);
    hold("rst_rel_hold", 2, 8'hFF);
    flt_en = 8'h00;
    io_in = 8'h00;
    hold("mix_prep_wait", 2, 8'hFF);
    step("mix_prep", 8'h00, 8'h00, 8'hFF);
    hold("mix_prep_hold", 2, 8'h00);
    flt_en = 8'h0F;
    flt_len = 4'd8;
    io_in = 8'hFF;
    hold("mix_wait", 2, 8'h00);
    step("mix_hi", 8'hF0, 8'hF0, 8'h00);
    hold("mix_mid", 6, 8'hF0);
    step("mix_lo", 8'hFF, 8'h0F, 8'h00);
    hold("mix_hold", 2, 8'hFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ef_gpio8_in_cond.md
EF_GPIO8_IN_COND -- requirements
Module: ef_gpio8_in_cond

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per pin, legal range 2..4.
REQ-002 The module SHALL have parameter FLT_W, default 4, the width of the filter length and of each per-bit stability counter.
REQ-003 Port clk, input, 1 bit: the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port io_in, input, 8 bits: raw asynchronous pad inputs.
REQ-006 Port flt_en, input, 8 bits: per-bit glitch-filter enable.
REQ-007 Port flt_len, input, FLT_W bits: number of consecutive differing samples required to accept a level change; 0 SHALL be treated as 1.
REQ-008 Port prescale, input, 8 bits: sample-tick divider; one tick every prescale+1 clocks.
REQ-009 Port datai, output, 8 bits: conditioned pin level, consumed by the GPIO data-in register.
REQ-010 Ports hi and lo, outputs, 8 bits each: level flags, hi = datai and lo = ~datai.
REQ-011 Ports pe and ne, outputs, 8 bits each: one-cycle rising-edge and falling-edge pulses on datai, feeding the interrupt raw status.

Function
REQ-012 Each io_in bit SHALL pass through SYNC_STAGES flops; the last stage is sync[i].
REQ-013 The prescaler SHALL be an 8-bit counter; when cnt >= prescale, tick=1 and cnt<=0; otherwise cnt<=cnt+1.
REQ-014 prescale=0 SHALL give a tick every clock; lowering prescale below the current cnt SHALL cause a tick and wrap on the next clock, with no lockup.
REQ-015 With flt_en[i]=0, datai[i] SHALL be registered from sync[i] every clock, ignoring tick, and flt_cnt[i] SHALL be held at 0.
REQ-016 With flt_en[i]=1, on a tick where sync[i]==datai[i], flt_cnt[i] SHALL clear to 0.
REQ-017 With flt_en[i]=1, on a tick where sync[i]!=datai[i] and flt_cnt[i]==L-1 (L = max(flt_len,1)), datai[i] SHALL toggle and flt_cnt[i] SHALL clear; otherwise flt_cnt[i] SHALL increment.
REQ-018 With flt_en[i]=1, on non-tick clocks datai[i] and flt_cnt[i] SHALL hold.
REQ-019 A pulse shorter than L consecutive differing ticks SHALL never change datai.
REQ-020 Latency at prescale=0 with the filter disabled SHALL be SYNC_STAGES+1 rising edges from the io_in change to datai; with the filter enabled it SHALL be SYNC_STAGES+L edges.
REQ-021 datai_d SHALL be the register datai delayed one clock; pe = datai & ~datai_d and ne = ~datai & datai_d, decoded from registers only.
REQ-022 pe[i] and ne[i] SHALL each be high for exactly one clock per accepted transition, and never both in the same cycle.
REQ-023 A change of flt_len mid-count SHALL take effect at the next tick, comparing the existing flt_cnt against the new L-1.
REQ-024 If flt_cnt >= the new L-1 after a flt_len change, the next differing tick SHALL toggle datai.
REQ-025 Toggling flt_en[i] from 1 to 0 SHALL clear flt_cnt[i]; datai[i] SHALL then follow sync[i] on the next clock.
REQ-026 All eight bits SHALL be independent; simultaneous changes on several bits SHALL each produce their own pulses in the same cycle.

Reset
REQ-027 While rst_n=0, all of the following SHALL be 0 immediately, without a clock: synchronizer flops, prescaler cnt, all flt_cnt, datai and datai_d.
REQ-028 During reset the outputs SHALL read datai=00, hi=00, lo=FF, pe=00 and ne=00.
REQ-029 Reset assertion mid-count SHALL abandon all pending filter counts.
REQ-030 After rst_n deasserts with io_in high, datai SHALL rise per REQ-020 and pe SHALL fire once.

Verification
REQ-031 Unfiltered path: reset, flt_en=00, prescale=0, io_in=00->A5 -> datai=A5 and pe=A5 for one clock, 3 edges after the change; pins switched back to 00 -> ne=A5 for one clock.
REQ-032 Glitch reject: flt_en=FF, flt_len=4, prescale=0, io_in[0] high for 3 clocks -> datai[0] stays 0 and pe=00 throughout.
REQ-033 Glitch accept: same settings as REQ-032, io_in[0] held high -> datai[0]=1 exactly 6 edges after the change and pe[0] pulses once.
REQ-034 Prescaled filter: prescale=9, flt_len=2, io_in=FF held -> datai=FF only after the 2nd differing tick, within 2+20 clocks; no change before the 2nd tick.
REQ-035 Reset mid-operation: rst_n pulled low during a count with io_in=FF -> outputs immediately read datai=00, lo=FF; after release datai reaches FF with a single pe=FF pulse.
REQ-036 Mixed per-bit modes: flt_en=0F, flt_len=8, io_in=00->FF -> upper nibble goes high at edge 3, lower nibble at edge 10, producing two separate pe pulses (F0, then 0F).
